// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the 8-deep FIFO with optional burst lock.
// The grant is zero-cycle: gnt and fifo_write_en follow req combinationally,
// and the FIFO accept rule (not full, or full with a same-cycle read) decides
// whether the selected beat is taken.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           gnt,
  input  logic                       fifo_full,
  input  logic                       fifo_read_en,
  output logic                       fifo_write_en,
  output logic [DATA_W-1:0]          fifo_write_data,
  output logic                       lock_valid,
  output logic [$clog2(N_REQ)-1:0]   lock_idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_ptr_n;
  logic [IDX_W-1:0]  lock_idx_n;
  logic [IDX_W-1:0]  sel;
  logic [IDX_W-1:0]  start;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  beat_n;
  logic [CNT_W-1:0]  beat_inc;
  logic              wr_req;
  logic              slot_ok;
  logic              accept;

  // Increment an index modulo N_REQ (N_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
    if (x == IDX_W'(N_REQ - 1)) next_idx = '0;
    else                        next_idx = x + IDX_W'(1);
  endfunction

  // First requester at or after 'from', wrapping; returns 'from' when none.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] from,
                                               input logic [N_REQ-1:0] r);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    idx   = from;
    pick  = from;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = next_idx(idx);
    end
    rr_pick = pick;
  endfunction

  // FIFO can take a beat this cycle; reset blocks every write.
  assign slot_ok       = !rst && (!fifo_full || fifo_read_en);
  assign fifo_write_en = wr_req && !rst;
  assign accept        = wr_req && slot_ok;
  assign beat_inc      = beat_cnt + CNT_W'(1);

  // Next-state, selection and write request.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    beat_n     = beat_cnt;
    lock_idx_n = lock_idx;
    sel        = rr_ptr;
    wr_req     = 1'b0;
    start      = (state == LOCK) ? next_idx(lock_idx) : rr_ptr;

    if (state == LOCK && req[lock_idx]) begin
      // Owner still requesting: keep pushing its beats until the cap.
      sel    = lock_idx;
      wr_req = 1'b1;
      if (wr_req && slot_ok) begin
        if (beat_inc == CNT_W'(MAX_BURST)) begin
          state_n  = IDLE;
          rr_ptr_n = next_idx(lock_idx);
          beat_n   = '0;
        end else begin
          beat_n = beat_inc;
        end
      end
    end else begin
      // Free arbitration; a released lock hands over in the same cycle.
      sel    = rr_pick(start, req);
      wr_req = |req;
      if (state == LOCK) begin
        state_n  = IDLE;
        rr_ptr_n = next_idx(lock_idx);
        beat_n   = '0;
      end
      if (wr_req && slot_ok) begin
        if (MAX_BURST == 1) begin
          rr_ptr_n = next_idx(sel);
        end else begin
          state_n    = LOCK;
          lock_idx_n = sel;
          beat_n     = CNT_W'(1);
        end
      end
    end
  end

  // Data mux and one-hot grant for the selected requester.
  always_comb begin
    fifo_write_data = '0;
    gnt             = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        fifo_write_data = req_data[i*DATA_W +: DATA_W];
        gnt[i]          = accept;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      lock_idx   <= '0;
      lock_valid <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      beat_cnt   <= beat_n;
      lock_idx   <= lock_idx_n;
      lock_valid <= (state_n == LOCK);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a burst-lock instance (MAX_BURST=4) in
// front of an 8-deep FIFO occupancy model, and a pure round-robin instance.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [N*DW-1:0] req_data;
  logic            fifo_full;
  logic            rd;
  logic            wen;
  logic [DW-1:0]   wdata;
  logic            lock_valid;
  logic [1:0]      lock_idx;

  logic [N-1:0]    req_r;
  logic [N-1:0]    gnt_r;
  logic [N*DW-1:0] req_data_r;
  logic            full_r = 1'b0;
  logic            rd_r   = 1'b1;
  logic            wen_r;
  logic [DW-1:0]   wdata_r;
  logic            lock_valid_r;
  logic [1:0]      lock_idx_r;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_read_en(rd), .fifo_write_en(wen),
    .fifo_write_data(wdata), .lock_valid(lock_valid), .lock_idx(lock_idx)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_r), .req_data(req_data_r), .gnt(gnt_r),
    .fifo_full(full_r), .fifo_read_en(rd_r), .fifo_write_en(wen_r),
    .fifo_write_data(wdata_r), .lock_valid(lock_valid_r), .lock_idx(lock_idx_r)
  );

  // 8-deep FIFO occupancy model using the FIFO's own accept rule.
  int occ = 0;
  assign fifo_full = (occ == 8);
  always @(posedge clk)
    occ <= occ + ((wen && (!fifo_full || rd)) ? 1 : 0) - ((rd && occ != 0) ? 1 : 0);

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t q_r[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur_t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dv(input int t, input int i);
    return {8'hA0, 8'(t), 8'h00, 8'(i)};
  endfunction

  function automatic logic [31:0] dv_r(input int t, input int i);
    return {8'hB0, 8'(t), 8'h00, 8'(i)};
  endfunction

  task automatic set_data(input int t);
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW]   = dv(t, i);
      req_data_r[i*DW +: DW] = dv_r(t, i);
    end
  endtask

  task automatic push(input int idx);
    exp_t e;
    e.idx  = idx;
    e.data = dv(cur_t, idx);
    q.push_back(e);
  endtask

  task automatic push_r(input int idx);
    exp_t e;
    e.idx  = idx;
    e.data = dv_r(cur_t, idx);
    q_r.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Confirm every expected beat was granted, then realign to posedge+1.
  task automatic qchk(input string name);
    @(negedge clk);
    #1;
    chk(name, 32'(q.size()), 32'd0);
    chk({name, "_rr"}, 32'(q_r.size()), 32'd0);
    tick();
  endtask

  // Scoreboard monitor, burst-lock instance.
  always @(negedge clk) begin
    if (gnt !== '0) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_dut: unexpected gnt %b data %h at %0t", gnt, wdata, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_dut_gnt", 32'(gnt), 32'd1 << e.idx);
        chk("sb_dut_data", wdata, e.data);
      end
    end
  end

  // Scoreboard monitor, round-robin instance.
  always @(negedge clk) begin
    if (gnt_r !== '0) begin
      if (q_r.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_rr: unexpected gnt %b data %h at %0t", gnt_r, wdata_r, $time);
      end else begin
        exp_t e;
        e = q_r.pop_front();
        chk("sb_rr_gnt", 32'(gnt_r), 32'd1 << e.idx);
        chk("sb_rr_data", wdata_r, e.data);
      end
    end
  end

  initial begin
    logic [1:7] lv1;
    rst   = 1'b1;
    req   = '0;
    req_r = '0;
    rd    = 1'b0;
    set_data(0);

    // Reset: a beat presented during reset is not written.
    tick();
    req = 4'b0100;
    smp();
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_lock_valid", 32'(lock_valid), 32'd0);
    chk("rst_lock_idx", 32'(lock_idx), 32'd0);
    chk("rst_rr_ptr", 32'(u_dut.rr_ptr), 32'd0);
    tick();
    rst = 1'b0;

    // Single requester 2, 4-beat burst then re-arbitration back to 2.
    cur_t = 1;
    set_data(1);
    lv1 = 7'b0111010;
    for (int c = 1; c <= 7; c++) begin
      req = (c <= 5) ? 4'b0100 : 4'b0000;
      if (c <= 5) push(2);
      smp();
      chk("t1_lock_valid", 32'(lock_valid), 32'(lv1[c]));
      if (c == 2) chk("t1_lock_idx", 32'(lock_idx), 32'd2);
      tick();
    end
    rd = 1'b1;
    repeat (6) tick();
    qchk("t1_done");

    // Burst cap with requesters 0 and 1 both active.
    cur_t = 3;
    set_data(3);
    for (int c = 1; c <= 10; c++) begin
      req = (c <= 9) ? 4'b0011 : 4'b0000;
      if (c <= 4 || c == 9) push(0);
      else if (c <= 8) push(1);
      smp();
      if (c == 2) chk("t3_lock_idx0", 32'(lock_idx), 32'd0);
      if (c == 5) chk("t3_rotate_lv", 32'(lock_valid), 32'd0);
      if (c == 6) chk("t3_lock_idx1", 32'(lock_idx), 32'd1);
      tick();
    end
    qchk("t3_done");

    // Fill to 8, stall while full, bypass on a simultaneous read.
    cur_t = 4;
    set_data(4);
    for (int c = 1; c <= 15; c++) begin
      rd  = (c == 11 || c == 14 || c == 15);
      req = (c <= 14) ? 4'b0010 : 4'b0000;
      if (c <= 8 || c == 11 || c == 14) push(1);
      smp();
      if (c == 9 || c == 10) begin
        chk("t4_stall_wen", 32'(wen), 32'd1);
        chk("t4_stall_gnt", 32'(gnt), 32'd0);
        chk("t4_stall_lv", 32'(lock_valid), 32'd0);
      end
      if (c == 11) chk("t4_bypass_gnt", 32'(gnt), 32'b0010);
      if (c == 12) chk("t4_occ_after_bypass", 32'(occ), 32'd8);
      if (c == 12 || c == 13) begin
        chk("t4_lstall_gnt", 32'(gnt), 32'd0);
        chk("t4_lstall_lv", 32'(lock_valid), 32'd1);
        chk("t4_lstall_idx", 32'(lock_idx), 32'd1);
        chk("t4_lstall_beat", 32'(u_dut.beat_cnt), 32'd1);
      end
      if (c == 15) chk("t4_beat_cnt", 32'(u_dut.beat_cnt), 32'd2);
      tick();
    end
    rd  = 1'b1;
    req = '0;
    repeat (9) tick();
    qchk("t4_done");

    // Early release: owner 3 drops with beat_cnt=2, requester 0 wins same cycle.
    cur_t = 5;
    set_data(5);
    for (int c = 1; c <= 5; c++) begin
      req = (c <= 2) ? 4'b1000 : (c == 3) ? 4'b0001 : 4'b0000;
      if (c <= 2) push(3);
      if (c == 3) push(0);
      smp();
      if (c == 3) begin
        chk("t5_pre_idx", 32'(lock_idx), 32'd3);
        chk("t5_pre_beat", 32'(u_dut.beat_cnt), 32'd2);
        chk("t5_handover_gnt", 32'(gnt), 32'b0001);
      end
      if (c == 4) begin
        chk("t5_new_idx", 32'(lock_idx), 32'd0);
        chk("t5_new_lv", 32'(lock_valid), 32'd1);
        chk("t5_new_beat", 32'(u_dut.beat_cnt), 32'd1);
      end
      if (c == 5) begin
        chk("t5_rel_lv", 32'(lock_valid), 32'd0);
        chk("t5_rel_rr", 32'(u_dut.rr_ptr), 32'd1);
      end
      tick();
    end
    qchk("t5_done");

    // Reset mid-burst drops the lock; first grant afterwards goes to 1.
    cur_t = 6;
    set_data(6);
    for (int c = 1; c <= 8; c++) begin
      rst = (c == 4);
      req = (c <= 4) ? 4'b0100 : (c == 5) ? 4'b1010 : (c == 6) ? 4'b1000 : 4'b0000;
      if (c <= 3) push(2);
      if (c == 5) push(1);
      if (c == 6) push(3);
      smp();
      if (c == 4) begin
        chk("t6_rst_wen", 32'(wen), 32'd0);
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_pre_lv", 32'(lock_valid), 32'd1);
        chk("t6_pre_beat", 32'(u_dut.beat_cnt), 32'd3);
      end
      if (c == 5) begin
        chk("t6_post_lv", 32'(lock_valid), 32'd0);
        chk("t6_post_rr", 32'(u_dut.rr_ptr), 32'd0);
        chk("t6_first_gnt", 32'(gnt), 32'b0010);
      end
      if (c == 7) begin
        chk("t6_handover_lv", 32'(lock_valid), 32'd1);
        chk("t6_handover_idx", 32'(lock_idx), 32'd3);
      end
      if (c == 8) chk("t6_end_lv", 32'(lock_valid), 32'd0);
      tick();
    end
    qchk("t6_done");

    // Pure round-robin instance: sparse pattern, then all four with wrap.
    cur_t = 2;
    set_data(2);
    for (int c = 1; c <= 14; c++) begin
      req_r = (c <= 3) ? 4'b1010 : (c >= 5 && c <= 13) ? 4'b1111 : 4'b0000;
      if (c == 1 || c == 3) push_r(1);
      if (c == 2) push_r(3);
      if (c >= 5 && c <= 13) push_r((c - 3) % 4);
      smp();
      if (c == 6) chk("t2_no_lock", 32'(lock_valid_r), 32'd0);
      if (c == 7) chk("t2_rr_wrap", 32'(u_rr.rr_ptr), 32'd0);
      if (c == 8) chk("t2_rr_gnt1", 32'(gnt_r), 32'b0010);
      tick();
    end
    qchk("t2_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
